traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//  Timed phase sequencer for a two-road intersection (main road, side road). Owns all phase timing:
//  main road rests green, side road is served on a latched demand, with yellow and all-red clearance.
//  Sits above the per-approach lamp drivers; drives one-hot {R,Y,G} lamps per road plus a phase code.
//  Enable-low drops the intersection into a flashing fail-safe mode.
// PARAMETERS
//  CNT_W      8   width of phase timer and flash counter
//  T_MAIN_MIN 20  minimum main-green cycles before side demand is honoured (>=1)
//  T_SIDE_G   10  side-green cycles, fixed (>=1)
//  T_YELLOW   4   yellow cycles, both roads (>=1)
//  T_ALL_RED  2   all-red clearance cycles (>=1)
//  T_FLASH    8   half-period of flash blink, cycles (>=1)
// PORTS
//  clk         in   1  clock, all logic on posedge
//  res         in   1  synchronous reset, active-high
//  en          in   1  1 = normal sequencing, 0 = flash mode
//  side_req    in   1  side-road vehicle sensor; any 1-cycle pulse is latched
//  main_light  out  3  {R,Y,G} one-hot, 3'b000 = dark (flash off half)
//  side_light  out  3  {R,Y,G} one-hot, 3'b000 = dark
//  phase       out  3  0 MAIN_G,1 MAIN_Y,2 ALL_R1,3 SIDE_G,4 SIDE_Y,5 ALL_R2,6 FLASH
//  tmr         out  CNT_W  current phase timer (remaining cycles - 1)
//  ped_req     in   1  [PED_WALK_EN only] pedestrian button, latched like side_req
//  walk        out  1  [PED_WALK_EN only] walk lamp for crossing the main road
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. res=1 at posedge: phase=ALL_R2, tmr=T_ALL_RED-1,
//    main_light=side_light=3'b100, req_pend=0, blink=0, walk=0. res dominates en and all requests.
//  - Timer: on entry to a timed phase tmr loads T-1, decrements each cycle; a phase of length T lasts
//    exactly T cycles. Transition occurs on the cycle where tmr==0 and exit condition holds.
//  - Transitions (en=1): ALL_R2 -> MAIN_G; MAIN_G -> MAIN_Y when tmr==0 and req_pend (tmr holds 0 while
//    no demand; main green rests indefinitely); MAIN_Y -> ALL_R1 -> SIDE_G -> SIDE_Y -> ALL_R2 -> MAIN_G.
//  - Lamps: MAIN_G main G/side R; MAIN_Y main Y/side R; SIDE_G main R/side G; SIDE_Y main R/side Y;
//    ALL_R1/ALL_R2 both R. Lamps registered, change same edge as phase.
//  - req_pend: set by side_req=1 in any phase; cleared on the edge entering SIDE_G. side_req=1 on that
//    same edge wins: req_pend stays 1 (demand served again after next T_MAIN_MIN).
//  - en=0 at any posedge (any phase): next phase=FLASH, blink=1, flash counter loads T_FLASH-1.
//    FLASH: blink toggles each T_FLASH cycles; main_light = blink?Y:dark, side_light = blink?R:dark.
//    tmr holds flash counter. req_pend retained (still latches requests).
//  - en 0->1 while in FLASH: next phase=ALL_R2, tmr=T_ALL_RED-1, then normal sequence.
//  - No illegal phase reachable; phase code 7 (decode default) forces ALL_R2 next cycle, both lamps R.
//  - Never two roads non-red simultaneously outside FLASH; every green->green path passes Y and all-red.
// CONFIGURATION
//  PED_WALK_EN defined: ped_req/walk ports present; ped_req latched into ped_pend (same set/clear rules
//    as req_pend, cleared entering SIDE_G); MAIN_G exit condition becomes req_pend|ped_pend; walk=1
//    exactly during SIDE_G entered with ped_pend=1, else 0; walk=0 in FLASH and on reset.
//  PED_WALK_EN undefined: ports absent, no ped_pend logic; behaviour as above.
// TESTING (defaults)
//  - Reset release, en=1, no reqs -> ALL_R2 2 cycles, then MAIN_G held for 200 cycles, tmr stays 0.
//  - side_req 1-cycle pulse at MAIN_G cycle 5 -> MAIN_G total 20 cycles, MAIN_Y 4, ALL_R1 2, SIDE_G 10,
//    SIDE_Y 4, ALL_R2 2, MAIN_G; req_pend 0 after SIDE_G entry.
//  - side_req pulse during SIDE_G -> after return, MAIN_G lasts exactly 20 cycles then MAIN_Y.
//  - en=0 mid SIDE_G (tmr=5) -> next cycle phase=6, main Y/side R on for 8, dark for 8, repeat;
//    en=1 -> ALL_R2 2 cycles, MAIN_G.
//  - res=1 for one cycle mid MAIN_Y with req_pend=1 -> next cycle both R, phase=5, req_pend=0.
//  - PED_WALK_EN: ped_req pulse only -> side served, walk=1 for exactly the 10 SIDE_G cycles;
//    side_req only -> walk stays 0.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer: main road rests green, side road served on latched demand.
// Optional pedestrian walk service over the main road is built in when PED_WALK_EN is defined.
module traffic_phase_sequencer #(
  parameter int CNT_W      = 8,
  parameter int T_MAIN_MIN = 20,
  parameter int T_SIDE_G   = 10,
  parameter int T_YELLOW   = 4,
  parameter int T_ALL_RED  = 2,
  parameter int T_FLASH    = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             side_req,
`ifdef PED_WALK_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] tmr
);

  localparam logic [2:0] PH_MAIN_G = 3'd0;
  localparam logic [2:0] PH_MAIN_Y = 3'd1;
  localparam logic [2:0] PH_ALL_R1 = 3'd2;
  localparam logic [2:0] PH_SIDE_G = 3'd3;
  localparam logic [2:0] PH_SIDE_Y = 3'd4;
  localparam logic [2:0] PH_ALL_R2 = 3'd5;
  localparam logic [2:0] PH_FLASH  = 3'd6;

  localparam logic [2:0] LAMP_R    = 3'b100;
  localparam logic [2:0] LAMP_Y    = 3'b010;
  localparam logic [2:0] LAMP_G    = 3'b001;
  localparam logic [2:0] LAMP_DARK = 3'b000;

  localparam logic [CNT_W-1:0] LD_MAIN    = CNT_W'(T_MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] LD_SIDE    = CNT_W'(T_SIDE_G - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_FLASH   = CNT_W'(T_FLASH - 1);

  logic [2:0]       phase_reg, phase_next;
  logic [CNT_W-1:0] tmr_reg, tmr_next, tmr_dec;
  logic             tmr_zero;
  logic             blink_reg, blink_next;
  logic             req_pend_reg, req_pend_next;
  logic             demand, enter_side;
  logic [2:0]       main_light_reg, main_light_next;
  logic [2:0]       side_light_reg, side_light_next;

`ifdef PED_WALK_EN
  logic ped_pend_reg, ped_pend_next;
  logic walk_reg, walk_next;
`endif

  // State register: phase, timer, blink, demand latches and the registered lamps.
  always_ff @(posedge clk) begin
    if (res) begin
      phase_reg      <= PH_ALL_R2;
      tmr_reg        <= LD_ALL_RED;
      blink_reg      <= 1'b0;
      req_pend_reg   <= 1'b0;
      main_light_reg <= LAMP_R;
      side_light_reg <= LAMP_R;
`ifdef PED_WALK_EN
      ped_pend_reg   <= 1'b0;
      walk_reg       <= 1'b0;
`endif
    end else begin
      phase_reg      <= phase_next;
      tmr_reg        <= tmr_next;
      blink_reg      <= blink_next;
      req_pend_reg   <= req_pend_next;
      main_light_reg <= main_light_next;
      side_light_reg <= side_light_next;
`ifdef PED_WALK_EN
      ped_pend_reg   <= ped_pend_next;
      walk_reg       <= walk_next;
`endif
    end
  end

  // Next-state logic: each timed phase runs until its timer reads zero, then reloads for the next.
  always_comb begin
    phase_next = phase_reg;
    tmr_next   = tmr_reg;
    blink_next = 1'b0;
    tmr_zero   = (tmr_reg == '0);
    tmr_dec    = tmr_reg - CNT_W'(1);
`ifdef PED_WALK_EN
    demand     = req_pend_reg | ped_pend_reg;
`else
    demand     = req_pend_reg;
`endif
    if (!en) begin
      phase_next = PH_FLASH;
      if (phase_reg != PH_FLASH) begin
        blink_next = 1'b1;
        tmr_next   = LD_FLASH;
      end else if (tmr_zero) begin
        blink_next = ~blink_reg;
        tmr_next   = LD_FLASH;
      end else begin
        blink_next = blink_reg;
        tmr_next   = tmr_dec;
      end
    end else begin
      case (phase_reg)
        PH_MAIN_G: begin
          // Main green rests at zero until a demand is pending.
          if (!tmr_zero) begin
            tmr_next = tmr_dec;
          end else if (demand) begin
            phase_next = PH_MAIN_Y;
            tmr_next   = LD_YELLOW;
          end
        end
        PH_MAIN_Y: begin
          if (tmr_zero) begin
            phase_next = PH_ALL_R1;
            tmr_next   = LD_ALL_RED;
          end else begin
            tmr_next = tmr_dec;
          end
        end
        PH_ALL_R1: begin
          if (tmr_zero) begin
            phase_next = PH_SIDE_G;
            tmr_next   = LD_SIDE;
          end else begin
            tmr_next = tmr_dec;
          end
        end
        PH_SIDE_G: begin
          if (tmr_zero) begin
            phase_next = PH_SIDE_Y;
            tmr_next   = LD_YELLOW;
          end else begin
            tmr_next = tmr_dec;
          end
        end
        PH_SIDE_Y: begin
          if (tmr_zero) begin
            phase_next = PH_ALL_R2;
            tmr_next   = LD_ALL_RED;
          end else begin
            tmr_next = tmr_dec;
          end
        end
        PH_ALL_R2: begin
          if (tmr_zero) begin
            phase_next = PH_MAIN_G;
            tmr_next   = LD_MAIN;
          end else begin
            tmr_next = tmr_dec;
          end
        end
        default: begin
          // Leaving flash and the unused code both restart through full all-red clearance.
          phase_next = PH_ALL_R2;
          tmr_next   = LD_ALL_RED;
        end
      endcase
    end
    enter_side    = (phase_next == PH_SIDE_G) && (phase_reg != PH_SIDE_G);
    // A new request on the serving edge stays latched for the next cycle round.
    req_pend_next = side_req | (req_pend_reg & ~enter_side);
`ifdef PED_WALK_EN
    ped_pend_next = ped_req | (ped_pend_reg & ~enter_side);
`endif
  end

  // Output logic: lamps decoded from the upcoming phase so they change on the same edge.
  always_comb begin
    main_light_next = LAMP_R;
    side_light_next = LAMP_R;
    case (phase_next)
      PH_MAIN_G: main_light_next = LAMP_G;
      PH_MAIN_Y: main_light_next = LAMP_Y;
      PH_SIDE_G: side_light_next = LAMP_G;
      PH_SIDE_Y: side_light_next = LAMP_Y;
      PH_FLASH: begin
        main_light_next = blink_next ? LAMP_Y : LAMP_DARK;
        side_light_next = blink_next ? LAMP_R : LAMP_DARK;
      end
      default: begin
        main_light_next = LAMP_R;
        side_light_next = LAMP_R;
      end
    endcase
`ifdef PED_WALK_EN
    walk_next = (phase_next == PH_SIDE_G) && (enter_side ? ped_pend_reg : walk_reg);
`endif
  end

  assign phase      = phase_reg;
  assign tmr        = tmr_reg;
  assign main_light = main_light_reg;
  assign side_light = side_light_reg;
`ifdef PED_WALK_EN
  assign walk       = walk_reg;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: one linear stimulus sequence, every cycle checked.
module tb_traffic_phase_sequencer;

  localparam logic [2:0] MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3, SY = 3'd4, AR2 = 3'd5, FL = 3'd6;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, DK = 3'b000;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       en = 1'b1;
  logic       side_req = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic [7:0] tmr;
`ifdef PED_WALK_EN
  logic       ped_req = 1'b0;
  logic       walk;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  traffic_phase_sequencer dut (
    .clk(clk),
    .res(res),
    .en(en),
    .side_req(side_req),
`ifdef PED_WALK_EN
    .ped_req(ped_req),
    .walk(walk),
`endif
    .main_light(main_light),
    .side_light(side_light),
    .phase(phase),
    .tmr(tmr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_raw(input string tag, input logic [2:0] ph, input logic [2:0] ml,
                         input logic [2:0] sl, input logic [7:0] t);
    logic [16:0] obs, exp;
    obs = {phase, main_light, side_light, tmr};
    exp = {ph, ml, sl, t};
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed phase/main/side/tmr=%0d/%b/%b/%0d required %0d/%b/%b/%0d",
             tag, phase, main_light, side_light, tmr, ph, ml, sl, t);
    end
`ifdef PED_WALK_EN
    total_cnt++;
    assert (walk === 1'b0) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s_walk: observed walk=%b required 0", tag, walk);
    end
`endif
  endtask

  // Lamp pairs for the normal phases, straight from the phase/lamp table.
  task automatic chk(input string tag, input logic [2:0] ph, input logic [7:0] t);
    logic [2:0] ml, sl;
    ml = R;
    sl = R;
    case (ph)
      MG: ml = G;
      MY: ml = Y;
      SG: sl = G;
      SY: sl = Y;
      default: ;
    endcase
    chk_raw(tag, ph, ml, sl, t);
  endtask

  task automatic seg(input string tag, input logic [2:0] ph, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, ph, 8'(start - i));
      step();
    end
  endtask

  task automatic hold_mg(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, MG, 8'd0);
      step();
    end
  endtask

  initial begin
    step();
    res = 1'b0;
    // Reset state, then resting main green with no demand.
    seg("rst_ar2", AR2, 1, 2);
    seg("mg_min", MG, 19, 20);
    hold_mg("mg_rest", 180);

    res = 1'b1;
    step();
    res = 1'b0;
    seg("ar2_b", AR2, 1, 2);
    seg("mg_a", MG, 19, 5);
    side_req = 1'b1;
    chk("mg_a_req", MG, 8'd14);
    step();
    side_req = 1'b0;
    seg("mg_a", MG, 13, 14);
    seg("my_1", MY, 3, 4);
    seg("ar1_1", AR1, 1, 2);
    seg("sg_1", SG, 9, 10);
    seg("sy_1", SY, 3, 4);
    seg("ar2_1", AR2, 1, 2);
    seg("mg_ret1", MG, 19, 20);
    hold_mg("mg_cleared", 30);

    // Pulse while resting: one more cycle of green, then yellow.
    side_req = 1'b1;
    chk("mg_dem", MG, 8'd0);
    step();
    side_req = 1'b0;
    chk("mg_dem2", MG, 8'd0);
    step();
    seg("my_2", MY, 3, 4);
    seg("ar1_2", AR1, 1, 2);
    seg("sg_2", SG, 9, 3);
    side_req = 1'b1;
    chk("sg_2_req", SG, 8'd6);
    step();
    side_req = 1'b0;
    seg("sg_2", SG, 5, 6);
    seg("sy_2", SY, 3, 4);
    seg("ar2_2", AR2, 1, 2);
    seg("mg_ret2", MG, 19, 20);

    seg("my_3", MY, 3, 4);
    seg("ar1_3", AR1, 1, 2);
    seg("sg_3", SG, 9, 4);
    en = 1'b0;
    chk("sg_3_en", SG, 8'd5);
    step();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        chk_raw("fl_on", FL, Y, R, 8'(7 - i));
        step();
      end
      for (int i = 0; i < 8; i++) begin
        chk_raw("fl_off", FL, DK, DK, 8'(7 - i));
        step();
      end
    end
    side_req = 1'b1;
    chk_raw("fl_req", FL, Y, R, 8'd7);
    step();
    side_req = 1'b0;
    en = 1'b1;
    chk_raw("fl_exit", FL, Y, R, 8'd6);
    step();
    seg("ar2_f", AR2, 1, 2);
    seg("mg_f", MG, 19, 20);

    // Request retained through flash; reset mid yellow must drop it.
    seg("my_r", MY, 3, 2);
    side_req = 1'b1;
    chk("my_r_req", MY, 8'd1);
    step();
    res = 1'b1;
    chk("my_r_rst", MY, 8'd0);
    step();
    res = 1'b0;
    side_req = 1'b0;
    seg("rst2_ar2", AR2, 1, 2);
    seg("mg_post", MG, 19, 20);
    hold_mg("mg_post_rest", 20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
